overlap_accumulate: RTL and testbench

OVERLAP_ACCUMULATE -- requirements
Module: overlap_accumulate

---
 rtl/overlap_accumulate.sv | 78 +++++++
 tb/tb_overlap_accumulate.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/overlap_accumulate.sv
// Carry-less overlap accumulator: XORs SEG partial products at H-bit offsets into one
// (SEG+1)*H-1 bit result, with an optional Karatsuba middle-term correction (SEG=3 only).
module overlap_accumulate #(
   parameter int H    = 13,
   parameter int SEG  = 3,
   parameter int KARA = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2*H-2:0]           in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [(SEG+1)*H-2:0]     out_data,
   output logic [2:0]               seg_idx
);

   localparam int          OW    = (SEG + 1) * H - 1;
   localparam logic [2:0]  LAST  = 3'(SEG - 1);
   localparam logic [0:0]  S_ACC = 1'b0;
   localparam logic [0:0]  S_OUT = 1'b1;

   logic [0:0]    r_state;
   logic [OW-1:0] r_acc;
   logic [2:0]    r_seg;
   logic [OW-1:0] w_term;
   logic          w_accept;
   logic          w_take;

   function automatic logic [OW-1:0] place(input logic [2*H-2:0] d, input int off);
      place = OW'(d) << off;
   endfunction

   assign in_ready  = (r_state == S_ACC) && !rst;
   assign out_valid = (r_state == S_OUT) && !rst;
   assign out_data  = rst ? '0 : r_acc;
   assign seg_idx   = rst ? 3'd0 : r_seg;
   assign w_accept  = in_valid && in_ready;
   assign w_take    = out_valid && out_ready;

   // Karatsuba: low and high products also fold into the middle term at offset H.
   always_comb begin
      w_term = place(in_data, int'(r_seg) * H);
      if (KARA == 1 && (r_seg == 3'd0 || r_seg == 3'd2))
         w_term = w_term ^ place(in_data, H);
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_state <= S_ACC;
         r_acc   <= '0;
         r_seg   <= 3'd0;
      end else begin
         case (r_state)
            S_ACC: begin
               if (w_accept) begin
                  r_acc <= r_acc ^ w_term;
                  if (r_seg == LAST) begin
                     r_seg   <= 3'd0;
                     r_state <= S_OUT;
                  end else begin
                     r_seg <= r_seg + 3'd1;
                  end
               end
            end
            default: begin
               if (w_take) begin
                  r_acc   <= '0;
                  r_state <= S_ACC;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_overlap_accumulate.sv
// Directed bench: a plain-mode and a Karatsuba-mode instance share one stimulus stream.
module tb_overlap_accumulate;

   localparam int H   = 13;
   localparam int SEG = 3;
   localparam int OW  = (SEG + 1) * H - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic [2*H-2:0] in_data;
   logic          out_ready;

   logic          p_in_ready, p_out_valid, k_in_ready, k_out_valid;
   logic [OW-1:0] p_out_data, k_out_data;
   logic [2:0]    p_seg_idx, k_seg_idx;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   overlap_accumulate #(.H(H), .SEG(SEG), .KARA(0)) u_plain (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(p_in_ready), .in_data(in_data),
      .out_valid(p_out_valid), .out_ready(out_ready), .out_data(p_out_data),
      .seg_idx(p_seg_idx)
   );

   overlap_accumulate #(.H(H), .SEG(SEG), .KARA(1)) u_kara (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(k_in_ready), .in_data(in_data),
      .out_valid(k_out_valid), .out_ready(out_ready), .out_data(k_out_data),
      .seg_idx(k_seg_idx)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [2*H-2:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic send3(input logic [2*H-2:0] a, input logic [2*H-2:0] b,
                        input logic [2*H-2:0] c);
      beat(a);
      beat(b);
      beat(c);
   endtask

   task automatic take();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("take_valid_drop", 64'(p_out_valid), 64'd0);
      chk("take_ready_back", 64'(p_in_ready), 64'd1);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      step();
      chk("rst_in_ready", 64'(p_in_ready), 64'd0);
      chk("rst_out_valid", 64'(p_out_valid), 64'd0);
      chk("rst_out_data", 64'(p_out_data), 64'd0);
      chk("rst_seg_idx", 64'(p_seg_idx), 64'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 64'(p_in_ready), 64'd1);

      // 1 + x^13 + x^26
      send3(25'h1, 25'h1, 25'h1);
      chk("ones_valid", 64'(p_out_valid), 64'd1);
      chk("ones_plain", 64'(p_out_data), 64'h4002001);
      chk("ones_kara", 64'(k_out_data), 64'h4002001);

      // Backpressure: out_ready low, in_valid high with junk data for 5 cycles
      in_valid = 1'b1;
      in_data  = 25'h155;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_data", 64'(p_out_data), 64'h4002001);
         chk("hold_in_ready", 64'(p_in_ready), 64'd0);
         chk("hold_seg", 64'(p_seg_idx), 64'd0);
         chk("hold_valid", 64'(p_out_valid), 64'd1);
      end
      take();
      in_valid = 1'b0;
      chk("take_data_clr", 64'(p_out_data), 64'd0);
      step();
      chk("idle_seg", 64'(p_seg_idx), 64'd0);
      chk("idle_valid", 64'(p_out_valid), 64'd0);

      // Middle bits cancel between segments 0 and 1
      send3(25'h1FFFFFF, 25'h1FFFFFF, 25'h0);
      chk("cancel_plain", 64'(p_out_data), 64'h3FFE001FFF);
      chk("cancel_kara", 64'(k_out_data), 64'h1FFFFFF);
      take();

      // Karatsuba: L + x^H(L^M^Hi) + x^2H*Hi
      send3(25'h1, 25'h1, 25'h0);
      chk("kara1_kara", 64'(k_out_data), 64'h1);
      chk("kara1_plain", 64'(p_out_data), 64'h2001);
      take();
      send3(25'h0, 25'h1, 25'h1);
      chk("kara2_kara", 64'(k_out_data), 64'h4000000);
      chk("kara2_plain", 64'(p_out_data), 64'h4002000);
      take();

      // Partial accumulator visibility after one beat
      beat(25'h7);
      chk("partial_seg", 64'(p_seg_idx), 64'd1);
      chk("partial_data", 64'(p_out_data), 64'h7);
      // Flush together with the second accept discards everything
      flush = 1'b1;
      beat(25'h3);
      flush = 1'b0;
      chk("flush_seg", 64'(p_seg_idx), 64'd0);
      chk("flush_data", 64'(p_out_data), 64'd0);
      chk("flush_ready", 64'(p_in_ready), 64'd1);
      send3(25'h2, 25'h3, 25'h4);
      chk("post_flush_plain", 64'(p_out_data), 64'h10006002);
      chk("post_flush_kara", 64'(k_out_data), 64'h1000A002);

      // Flush while holding a result drops it
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_out_valid", 64'(p_out_valid), 64'd0);
      chk("flush_out_data", 64'(p_out_data), 64'd0);

      // Reset while in OUT
      send3(25'h1, 25'h1, 25'h1);
      chk("pre_rst_valid", 64'(p_out_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("rst_out_comb_valid", 64'(p_out_valid), 64'd0);
      chk("rst_out_comb_ready", 64'(p_in_ready), 64'd0);
      step();
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 64'(p_out_valid), 64'd0);
      chk("rst_out_data0", 64'(p_out_data), 64'd0);
      chk("rst_out_ready", 64'(p_in_ready), 64'd1);

      // Reset after one accept
      beat(25'h9);
      chk("mid_seg", 64'(p_seg_idx), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("mid_rst_seg", 64'(p_seg_idx), 64'd0);
      chk("mid_rst_data", 64'(p_out_data), 64'd0);
      chk("mid_rst_valid", 64'(p_out_valid), 64'd0);

      // Full-width top segment exercises the highest accumulator bit
      send3(25'h1, 25'h2, 25'h1FFFFFF);
      chk("top_plain", 64'(p_out_data), 64'h7FFFFFC004001);
      chk("top_kara", 64'(k_out_data), 64'h7FFFFFC000000 ^ 64'h3FFFFF8000 ^ 64'h1);
      chk("top_kara_valid", 64'(k_out_valid), 64'd1);
      take();
      chk("end_kara_ready", 64'(k_in_ready), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
